// File: rtl/rect_fill_drawer_if.sv
// rtl/rect_fill_drawer_if.sv - draw request and pixel-output signals of the rectangle filler
interface rect_fill_drawer_if;
  logic       start;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] w;
  logic [6:0] h;
  logic [2:0] colour_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output start, x0, y0, w, h, colour_in,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, x0, y0, w, h, colour_in,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/rect_fill_drawer.sv
// rtl/rect_fill_drawer.sv - raster-order solid rectangle filler driving a VGA pixel port
module rect_fill_drawer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic               clock,
  input  logic               resetn,
  rect_fill_drawer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

  localparam logic [8:0] W_LIM = 9'(SCREEN_W);
  localparam logic [8:0] H_LIM = 9'(SCREEN_H);

  state_t     state, state_nxt;
  logic [8:0] cx, cy, lx0, end_x, end_y;
  logic [8:0] nx, ny;
  logic       row_end, last, empty;

  logic [7:0] x_q, x_nxt;
  logic [6:0] y_q, y_nxt;
  logic [2:0] colour_q, colour_nxt;
  logic       plot_q, plot_nxt;
  logic       busy_q, busy_nxt;
  logic       done_q, done_nxt;

  function automatic logic on_screen(input logic [8:0] px, input logic [8:0] py);
    return (px < W_LIM) && (py < H_LIM);
  endfunction

  // cx/cy hold the pixel currently on the outputs; nx/ny is the one after it
  always_comb begin
    empty   = (bus.w == 8'd0) || (bus.h == 7'd0);
    row_end = (cx == end_x);
    last    = row_end && (cy == end_y);
    nx      = row_end ? lx0 : cx + 9'd1;
    ny      = row_end ? cy + 9'd1 : cy;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= IDLE;
      cx       <= '0;
      cy       <= '0;
      lx0      <= '0;
      end_x    <= '0;
      end_y    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      x_q      <= x_nxt;
      y_q      <= y_nxt;
      colour_q <= colour_nxt;
      plot_q   <= plot_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      if (state == IDLE && bus.start) begin
        lx0   <= {1'b0, bus.x0};
        cx    <= {1'b0, bus.x0};
        cy    <= {2'b0, bus.y0};
        end_x <= {1'b0, bus.x0} + {1'b0, bus.w} - 9'd1;
        end_y <= {2'b0, bus.y0} + {2'b0, bus.h} - 9'd1;
      end else if (state == DRAW) begin
        cx <= nx;
        cy <= ny;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = empty ? FIN : DRAW;
      DRAW:    if (last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Off-screen pixels still take their cycle; only the strobe is suppressed
  always_comb begin
    x_nxt      = x_q;
    y_nxt      = y_q;
    colour_nxt = colour_q;
    plot_nxt   = 1'b0;
    busy_nxt   = (state_nxt == DRAW);
    done_nxt   = (state_nxt == FIN);
    if (state == IDLE && bus.start && !empty) begin
      x_nxt      = bus.x0;
      y_nxt      = bus.y0;
      colour_nxt = bus.colour_in;
      plot_nxt   = on_screen({1'b0, bus.x0}, {2'b0, bus.y0});
    end else if (state == DRAW && !last) begin
      x_nxt    = nx[7:0];
      y_nxt    = ny[6:0];
      plot_nxt = on_screen(nx, ny);
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
